// File: rtl/sine_dds_sched.sv
// Multi-channel DDS scheduler: per-channel phase accumulators share one sine ROM
// through a round-robin arbiter; samples return tagged with their channel index.
module sine_dds_sched #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 24,
    parameter int CH_W    = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH-1:0]         ch_clr,
    input  logic [NUM_CH*PHASE_W-1:0] ch_ftw,
    output logic [NUM_CH-1:0]         ch_ack,
    output logic [7:0]                rom_addr,
    input  logic [15:0]               rom_data,
    output logic                      out_valid,
    output logic [CH_W-1:0]           out_ch,
    output logic [15:0]               out_sample
);

    logic [PHASE_W-1:0] phase_r [NUM_CH];
    logic [CH_W-1:0]    last_r;
    logic [NUM_CH-1:0]  elig_s;
    logic               grant_s;
    logic [CH_W-1:0]    grant_ch_s;
    logic [CH_W-1:0]    cand_s;
    logic [NUM_CH-1:0]  ack_next_s;
    logic [CH_W-1:0]    ack_ch_r;
    logic               stg1_valid_r;
    logic [CH_W-1:0]    stg1_ch_r;

    // A clear in the same cycle masks the request so the cleared channel is skipped
    assign elig_s = ch_req & ~ch_clr & {NUM_CH{en}};

    // Round-robin search starting just after the last granted channel
    always_comb begin
        grant_s    = 1'b0;
        grant_ch_s = {CH_W{1'b0}};
        cand_s     = {CH_W{1'b0}};
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_s = last_r + k[CH_W-1:0];
            if (!grant_s && elig_s[cand_s]) begin
                grant_s    = 1'b1;
                grant_ch_s = cand_s;
            end else begin
                grant_s    = grant_s;
            end
        end
    end

    // One-hot acknowledge for the winning channel
    always_comb begin
        ack_next_s = {NUM_CH{1'b0}};
        if (grant_s) begin
            ack_next_s[grant_ch_s] = 1'b1;
        end else begin
            ack_next_s = {NUM_CH{1'b0}};
        end
    end

    // Phase accumulators: clear wins, otherwise advance only on a grant
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase_r[i] <= {PHASE_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clr[i]) begin
                    phase_r[i] <= {PHASE_W{1'b0}};
                end else if (grant_s && (grant_ch_s == CH_W'(i))) begin
                    phase_r[i] <= phase_r[i] + ch_ftw[i*PHASE_W +: PHASE_W];
                end else begin
                    phase_r[i] <= phase_r[i];
                end
            end
        end
    end

    // Grant registers: ack pulse, ROM address from pre-increment phase, rr pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ch_ack   <= {NUM_CH{1'b0}};
            rom_addr <= 8'h00;
            last_r   <= CH_W'(NUM_CH - 1);
            ack_ch_r <= {CH_W{1'b0}};
        end else begin
            ch_ack <= ack_next_s;
            if (grant_s) begin
                rom_addr <= phase_r[grant_ch_s][PHASE_W-1 -: 8];
                last_r   <= grant_ch_s;
                ack_ch_r <= grant_ch_s;
            end else begin
                rom_addr <= rom_addr;
                last_r   <= last_r;
                ack_ch_r <= ack_ch_r;
            end
        end
    end

    // Tag pipeline: stage 1 spans the ROM register, stage 2 captures its data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg1_valid_r <= 1'b0;
            stg1_ch_r    <= {CH_W{1'b0}};
            out_valid    <= 1'b0;
            out_ch       <= {CH_W{1'b0}};
            out_sample   <= 16'h0000;
        end else begin
            stg1_valid_r <= |ch_ack;
            stg1_ch_r    <= ack_ch_r;
            out_valid    <= stg1_valid_r;
            if (stg1_valid_r) begin
                out_ch     <= stg1_ch_r;
                out_sample <= rom_data;
            end else begin
                out_ch     <= out_ch;
                out_sample <= out_sample;
            end
        end
    end

endmodule

// File: tb/tb_sine_dds_sched.sv
// Directed bench for sine_dds_sched with a ROM model and a cycle-level reference model.
module tb_sine_dds_sched;

    localparam int NUM_CH  = 4;
    localparam int PHASE_W = 24;
    localparam int CH_W    = 2;

    logic                      clock = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      en = 1'b0;
    logic [NUM_CH-1:0]         ch_req = '0;
    logic [NUM_CH-1:0]         ch_clr = '0;
    logic [NUM_CH*PHASE_W-1:0] ch_ftw = '0;
    logic [NUM_CH-1:0]         ch_ack;
    logic [7:0]                rom_addr;
    logic [15:0]               rom_data = 16'h0000;
    logic                      out_valid;
    logic [CH_W-1:0]           out_ch;
    logic [15:0]               out_sample;

    sine_dds_sched #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .CH_W(CH_W)) dut (
        .clock(clock), .reset_n(reset_n), .en(en), .ch_req(ch_req), .ch_clr(ch_clr),
        .ch_ftw(ch_ftw), .ch_ack(ch_ack), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ch(out_ch), .out_sample(out_sample)
    );

    initial forever #5 clock = ~clock;

    // sine ROM: amplitude 16383, truncated toward zero, registered output
    logic [15:0] rom_tbl [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            int v;
            v = $rtoi(16383.0 * $sin(2.0 * 3.14159265358979 * i / 256.0));
            rom_tbl[i] = v[15:0];
        end
    end
    always @(posedge clock) rom_data <= rom_tbl[rom_addr];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string nm, input int act[$], input int exp[$]);
        chk({nm, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk(nm, (i < act.size()) ? act[i] : -1, exp[i]);
        end
    endtask

    // reference model: per-period expectations kept in a small ring
    logic [PHASE_W-1:0] m_phase [NUM_CH];
    int                 m_last = NUM_CH - 1;
    logic [7:0]         m_addr = 8'h00;
    logic [NUM_CH-1:0]  e_ack [8];
    bit                 e_val [8];
    int                 e_ch  [8];
    logic [15:0]        e_smp [8];
    int                 cyc = 0;

    task automatic m_clear();
        for (int c = 0; c < NUM_CH; c++) m_phase[c] = '0;
        for (int s = 0; s < 8; s++) begin
            e_ack[s] = '0; e_val[s] = 1'b0; e_ch[s] = 0; e_smp[s] = 16'h0000;
        end
        m_last = NUM_CH - 1;
        m_addr = 8'h00;
    endtask

    initial m_clear();
    initial forever begin
        @(negedge reset_n);
        m_clear();
    end

    initial forever begin
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            m_clear();
        end else begin
            int g;
            g = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (g < 0 && en && ch_req[c] && !ch_clr[c]) g = c;
            end
            e_ack[cyc % 8] = '0;
            e_val[(cyc + 2) % 8] = 1'b0;
            for (int c = 0; c < NUM_CH; c++) if (ch_clr[c]) m_phase[c] = '0;
            if (g >= 0) begin
                e_ack[cyc % 8][g] = 1'b1;
                m_addr = m_phase[g][PHASE_W-1 -: 8];
                m_phase[g] = m_phase[g] + ch_ftw[g*PHASE_W +: PHASE_W];
                m_last = g;
                e_val[(cyc + 2) % 8] = 1'b1;
                e_ch[(cyc + 2) % 8] = g;
                e_smp[(cyc + 2) % 8] = rom_tbl[m_addr];
            end
        end
    end

    // observation logs used by the directed literal checks
    int ack_ch_q[$], ack_addr_q[$], ack_cyc_q[$], ov_ch_q[$], ov_smp_q[$], ov_cyc_q[$];

    task automatic clear_logs();
        ack_ch_q.delete(); ack_addr_q.delete(); ack_cyc_q.delete();
        ov_ch_q.delete(); ov_smp_q.delete(); ov_cyc_q.delete();
    endtask

    // compare process: every cycle, away from the active edge
    initial forever begin
        @(negedge clock);
        #2;
        chk("ack", ch_ack, e_ack[cyc % 8]);
        chk("rom_addr", rom_addr, m_addr);
        chk("out_valid", out_valid, e_val[cyc % 8]);
        if (e_val[cyc % 8]) begin
            chk("out_ch", out_ch, e_ch[cyc % 8]);
            chk("out_sample", out_sample, e_smp[cyc % 8]);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_ack[c]) begin
                ack_ch_q.push_back(c); ack_addr_q.push_back(rom_addr); ack_cyc_q.push_back(cyc);
            end
        end
        if (out_valid) begin
            ov_ch_q.push_back(out_ch); ov_smp_q.push_back(out_sample); ov_cyc_q.push_back(cyc);
        end
    end

    task automatic grant_once(input int c);
        @(negedge clock); ch_req[c] = 1'b1;
        @(negedge clock); ch_req[c] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic set_ftw(input int c, input logic [PHASE_W-1:0] f);
        ch_ftw[c*PHASE_W +: PHASE_W] = f;
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_ack"}, ch_ack, 0);
        chk({nm, "_addr"}, rom_addr, 0);
        chk({nm, "_ov"}, out_valid, 0);
        chk({nm, "_och"}, out_ch, 0);
        chk({nm, "_smp"}, out_sample, 0);
    endtask

    initial begin
        int e[$], e2[$];
        repeat (2) @(negedge clock);
        #1 chk_zero_outputs("reset");
        reset_n = 1'b1;
        en = 1'b1;

        // single channel step
        set_ftw(0, 24'h010000);
        clear_logs();
        repeat (3) grant_once(0);
        repeat (4) @(negedge clock);
        e = '{0, 1, 2}; chk_seq("t1_addr", ack_addr_q, e);
        e = '{0, 16'h0192, 16'h0323}; chk_seq("t1_smp", ov_smp_q, e);
        chk("t1_gap", ack_cyc_q[1] - ack_cyc_q[0], 2);
        chk("t1_lat", ov_cyc_q[0] - ack_cyc_q[0], 2);

        // quarter step with wrap
        set_ftw(1, 24'h400000);
        clear_logs();
        repeat (5) grant_once(1);
        repeat (4) @(negedge clock);
        e = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00}; chk_seq("t2_addr", ack_addr_q, e);
        e = '{16'h0000, 16'h3fff, 16'h0000, 16'hc001, 16'h0000}; chk_seq("t2_smp", ov_smp_q, e);
        e = '{1, 1, 1, 1, 1}; chk_seq("t2_ch", ov_ch_q, e);

        // round-robin with all requests held
        do_reset();
        set_ftw(2, 24'h123456); set_ftw(3, 24'h0fedcb);
        clear_logs();
        @(negedge clock); ch_req = 4'b1111;
        repeat (8) @(negedge clock);
        ch_req = 4'b0000;
        repeat (4) @(negedge clock);
        e = '{0, 1, 2, 3, 0, 1, 2, 3}; chk_seq("t3_ack", ack_ch_q, e);
        chk_seq("t3_och", ov_ch_q, e);
        chk("t3_rate", ov_cyc_q[ov_cyc_q.size()-1] - ov_cyc_q[0], 7);

        // clear versus request, with a grant to another channel
        do_reset();
        set_ftw(2, 24'h400000);
        repeat (2) grant_once(2);
        @(negedge clock); ch_clr[2] = 1'b1; ch_req[2] = 1'b1; ch_req[0] = 1'b1;
        @(negedge clock);
        #1 chk("t4_clr_ack", ch_ack, 4'b0001);
        ch_clr[2] = 1'b0; ch_req[0] = 1'b0;
        @(negedge clock);
        #1 chk("t4_ack2", ch_ack, 4'b0100);
        chk("t4_addr", rom_addr, 8'h00);
        ch_req[2] = 1'b0;
        repeat (4) @(negedge clock);

        // enable drain: two grants in flight, then en low
        do_reset();
        set_ftw(0, 24'h100000); set_ftw(1, 24'h200000);
        repeat (2) grant_once(0);
        grant_once(1);
        repeat (3) @(negedge clock);
        clear_logs();
        ch_req[0] = 1'b1; ch_req[1] = 1'b1;
        repeat (2) @(negedge clock);
        en = 1'b0;
        repeat (6) @(negedge clock);
        e = '{0, 1}; chk_seq("t5_ack", ack_ch_q, e);
        e2 = '{0, 1}; chk_seq("t5_och", ov_ch_q, e2);
        e = '{16'h2d40, 16'h2d40}; chk_seq("t5_smp", ov_smp_q, e);
        ch_req = 4'b0000;
        @(negedge clock); en = 1'b1;

        // reset mid-stream
        @(negedge clock); ch_req = 4'b1111;
        repeat (3) @(negedge clock);
        reset_n = 1'b0; ch_req = 4'b0000;
        #1 chk_zero_outputs("t6_rst");
        @(negedge clock); reset_n = 1'b1;
        clear_logs();
        repeat (4) @(negedge clock);
        chk("t6_no_ov", ov_cyc_q.size(), 0);
        @(negedge clock); ch_req = 4'b1111;
        @(negedge clock);
        #1 chk("t6_ack", ch_ack, 4'b0001);
        chk("t6_addr", rom_addr, 8'h00);
        ch_req = 4'b0000;
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sine_dds_sched.md
# sine_dds_sched

Multi-channel direct digital synthesis (DDS) scheduler that shares one 256-entry, 16-bit signed `sine_rom` among `NUM_CH` channels. It holds a phase accumulator per channel and arbitrates sample requests round-robin, granting at most one per cycle. For each grant it drives the ROM address and returns the registered ROM output, tagged with the channel index. The block sits between the per-channel sample consumers (mixers/modulators) and the single shared ROM instance.

## Interface
- `NUM_CH`, default 4: channel count; power of two, 2..8.
- `PHASE_W`, default 24: phase accumulator width, ≥ 8.
- `CH_W`, default 2: channel index width, equal to log2(`NUM_CH`).

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: global enable; when low, no new grants are issued.
- `ch_req`  in  NUM_CH: per-channel sample request, level-sensitive; the requester holds it until acknowledged.
- `ch_clr`  in  NUM_CH: per-channel phase clear, synchronous.
- `ch_ftw`  in  NUM_CH*PHASE_W: frequency tuning words; channel i occupies bits [i*PHASE_W +: PHASE_W].
- `ch_ack`  out  NUM_CH: one-hot, 1-cycle grant pulse.
- `rom_addr`  out  8: address to `sine_rom`.
- `rom_data`  in  16: signed `sine_rom` output; the ROM registers it one cycle after the address.
- `out_valid`  out  1: 1-cycle sample strobe.
- `out_ch`  out  CH_W: channel index of the sample.
- `out_sample`  out  16: signed sine sample.

## Operation
- Each channel i has a `phase[i]` register of width PHASE_W.
- **Eligibility:** channel i is eligible when `en` && `ch_req[i]` && !`ch_clr[i]`.
- **Arbitration:** round-robin. Search starts at `last+1` and wraps modulo NUM_CH. The first eligible channel g is granted.
- **On a grant to g:**
  - `ch_ack[g]` = 1.
  - `rom_addr` <= `phase[g][PHASE_W-1 -: 8]`, using the pre-increment phase.
  - `phase[g]` <= `phase[g] + ftw[g]` modulo 2^PHASE_W (wrap, no saturation).
  - `last` <= g.
- **With no grant:** `ch_ack` = 0, `rom_addr` holds its value, `last` is unchanged.
- **Clear:** `ch_clr[i]` sets `phase[i]` <= 0. Clear takes priority over a request in the same cycle, so the channel is not granted that cycle.
- `ftw` is sampled at the grant edge only, so changing it has no effect on samples already issued.
- **Result pipeline:** the grant tag (valid, channel) is delayed 2 stages to line up with `rom_data`.
  - Stage 1 covers the ROM register.
  - Stage 2 drives `out_valid`, `out_ch`, and `out_sample` <= `rom_data`.
- **Drain:** dropping `en` stops new grants. Any samples already in flight still complete.
- **No backpressure:** consumers must accept `out_valid` on the cycle it is asserted.

## Timing
- **Reset values** (asynchronous, while `reset_n` = 0):
  - `phase[*]` = 0 and `last` = NUM_CH-1, so channel 0 has first priority.
  - `ch_ack` = 0 and `rom_addr` = 0x00.
  - `out_valid` = 0, `out_ch` = 0, `out_sample` = 0x0000.
  - The pipeline is flushed.
- `ch_ack` is a registered output asserted in the cycle after the requesting edge, coincident with the new `rom_addr`.
- **Latency:** `out_valid` asserts exactly 2 cycles after the corresponding `ch_ack`. Throughput is 1 sample per cycle.
- A requester sees `ch_ack` one cycle late, so it must deassert `ch_req` in the ack cycle. If `ch_req` is still high at that edge, it is a new request.
- Reset asserted mid-stream discards all in-flight samples; no `out_valid` appears after reset release until a new grant.
- `ch_clr` and a grant to a different channel can occur in the same cycle, and both take effect.

## Test plan
- **Single channel step:** ch0 with ftw=0x010000 and `ch_req` high, one grant per 2 cycles. Required: `rom_addr` 0x00, 0x01, 0x02, …; `out_sample` 0x0000, 0x0192, 0x0323, 2 cycles after each ack.
- **Quarter step with wrap:** ch1 with ftw=0x400000, 5 grants. Required: addresses 0x00, 0x40, 0x80, 0xC0, 0x00; samples 0x0000, 0x3fff, 0x0000, 0xc001, 0x0000 with `out_ch`=1.
- **Round-robin:** all 4 `ch_req` held high with `en`=1 after reset. Required: ack order 0,1,2,3,0,1…; `out_ch` follows the same order with 2-cycle lag; one `out_valid` every cycle.
- **Clear vs. request:** ch2 has accumulated phase 0x800000, then `ch_clr[2]` and `ch_req[2]` are asserted in the same cycle. Required: no ack to ch2 that cycle; the next ch2 grant gives address 0x00 and sample 0x0000.
- **Enable drain:** `en` drops one cycle after a grant. Required: no further acks; the 2 in-flight samples still emerge with correct values.
- **Reset mid-stream:** pulse `reset_n` low while `out_valid` activity is pending. Required: all outputs 0 immediately; phases 0; the first post-reset grant goes to ch0 with address 0x00.
